// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
package rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_NREGS  = 32;

    // Address width needed to index n registers.
    function automatic int unsigned rf_aw(input int unsigned n);
        for (int unsigned w = 0; w < 32; w++) begin
            if ((64'd1 << w) >= 64'(n)) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two write ports, scoreboard set,
// pending count and the debug read port.
interface reg_file_mp_if
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned NREGS  = RF_NREGS,
    parameter int unsigned NRD    = 2
);
    localparam int unsigned AW = rf_aw(NREGS);

    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_pending;

    logic                  wr0_en;
    logic [AW-1:0]         wr0_addr;
    logic [DATA_W-1:0]     wr0_data;

    logic                  wr1_en;
    logic [AW-1:0]         wr1_addr;
    logic [DATA_W-1:0]     wr1_data;

    logic                  sb_set_en;
    logic [AW-1:0]         sb_set_addr;
    logic [AW:0]           pend_cnt;

    logic [AW-1:0]         dbg_addr;
    logic [DATA_W-1:0]     dbg_data;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr, dbg_addr,
        input  rd_data, rd_pending, pend_cnt, dbg_data
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr, dbg_addr,
        output rd_data, rd_pending, pend_cnt, dbg_data
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: register select, address-0 zeroing,
// optional same-cycle write forwarding and pending-bit lookup.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned NREGS  = RF_NREGS,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = rf_aw(NREGS)
) (
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] regs [NREGS],
    input  logic [NREGS-1:0]  pend,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    output logic [DATA_W-1:0] data,
    output logic              pending
);

    // Select stored value, then override with forwarded write data (wr1 first).
    // A same-cycle wr1 hides the pending bit unless a set hits the same register.
    always_comb begin
        data    = regs[addr];
        pending = pend[addr];
        if (addr == '0) begin
            data    = '0;
            pending = 1'b0;
        end else if (BYPASS) begin
            if (wr1_en && wr1_addr == addr) begin
                data = wr1_data;
                if (!(set_en && set_addr == addr)) pending = 1'b0;
            end else if (wr0_en && wr0_addr == addr) begin
                data = wr0_data;
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, a pending-write scoreboard
// with population count, and a non-forwarding debug read port.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned NREGS  = RF_NREGS,
    parameter int unsigned NRD    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_mp_if.slave bus
);

    localparam int unsigned AW = rf_aw(NREGS);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pend;
    logic [NREGS-1:0]  pend_nxt;
    logic [AW:0]       cnt;

    logic wr1_hit;
    logic set_hit;
    logic set_new;
    logic clr_eff;

    assign wr1_hit = bus.wr1_en && (bus.wr1_addr != '0);
    assign set_hit = bus.sb_set_en && (bus.sb_set_addr != '0);

    // Count only real transitions: a set on a pending bit is a no-op, and a
    // clear colliding with a set on the same register is overridden by it.
    assign set_new = set_hit && !pend[bus.sb_set_addr];
    assign clr_eff = wr1_hit && pend[bus.wr1_addr]
                     && !(set_hit && (bus.sb_set_addr == bus.wr1_addr));

    // Register storage; wr1 overrides wr0 on the same address, register 0 stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (bus.wr1_en && bus.wr1_addr == AW'(i)) begin
                    regs[i] <= bus.wr1_data;
                end else if (bus.wr0_en && bus.wr0_addr == AW'(i)) begin
                    regs[i] <= bus.wr0_data;
                end
            end
        end
    end

    // Next pending vector: wr1 clears, set applied last so it wins.
    always_comb begin
        pend_nxt = pend;
        if (wr1_hit) pend_nxt[bus.wr1_addr] = 1'b0;
        if (set_hit) pend_nxt[bus.sb_set_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Pending bits and their running count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pend_nxt;
            if (set_new && !clr_eff) begin
                cnt <= cnt + 1'b1;
            end else if (clr_eff && !set_new) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.pend_cnt = cnt;
    assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : regs[bus.dbg_addr];

    logic [DATA_W-1:0] rd_data_a [NRD];
    logic [NRD-1:0]    rd_pend_a;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        rf_read_port #(
            .DATA_W (DATA_W),
            .NREGS  (NREGS),
            .BYPASS (BYPASS)
        ) u_rd (
            .addr     (bus.rd_addr[g*AW +: AW]),
            .regs     (regs),
            .pend     (pend),
            .wr0_en   (bus.wr0_en),
            .wr0_addr (bus.wr0_addr),
            .wr0_data (bus.wr0_data),
            .wr1_en   (bus.wr1_en),
            .wr1_addr (bus.wr1_addr),
            .wr1_data (bus.wr1_data),
            .set_en   (bus.sb_set_en),
            .set_addr (bus.sb_set_addr),
            .data     (rd_data_a[g]),
            .pending  (rd_pend_a[g])
        );
    end

    // Pack per-port read data onto the bus.
    always_comb begin
        bus.rd_data = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = rd_data_a[i];
        end
    end

    assign bus.rd_pending = rd_pend_a;

endmodule
